u_seq_div: RTL and testbench

Sequential unsigned restoring divider: the inverse of the unsigned array multiplier. It takes an N-bit dividend and an N-bit divisor and produces quotient and remainder packed into a 2N-bit output, at one quotient bit per clock. It pairs with the multiplier in arithmetic round-trip benches (a·b → out → out/b) and is the first clocked arithmetic block alongside the combinational circuits.

---
 rtl/u_seq_div.sv | 113 +++++++++++
 tb/tb_u_seq_div.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/u_seq_div.sv
// u_seq_div: sequential unsigned restoring divider, one quotient bit per clock.
//   Parameter N (default 4): operand width, N >= 1.
//   clk, rst        : rising-edge clock, synchronous active-high reset.
//   start           : request, sampled only while idle (busy = 0).
//   a, b            : dividend / divisor, captured on the accepted start edge.
//   busy            : high while a division is in progress.
//   done            : one-cycle pulse when out is written.
//   div_by_zero     : divisor was zero for the latest accepted operation.
//   out[2N-1:0]     : {remainder, quotient}, held until the next done.
// Optional macro U_SEQ_DIV_ZERO_FAST_EN: a zero divisor skips the iteration
// and completes one cycle after accept with the same result.
module u_seq_div #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic [2*N-1:0] out
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [N-1:0]  q;     // dividend shifting out, quotient shifting in
  logic [N-1:0]  d;     // captured divisor
  logic [N-1:0]  r;     // partial remainder; always < divisor after restore, so N bits suffice
  logic [CW-1:0] cnt;   // iterations remaining minus one

`ifdef U_SEQ_DIV_ZERO_FAST_EN
  logic          zf;    // zero-divisor shortcut pending
`endif

  logic [N:0]    r_sh;
  logic [N:0]    diff;
  logic          ge;
  logic [N:0]    q_ext;
  logic [N-1:0]  q_nx;
  logic [N-1:0]  r_nx;

  // One restoring iteration: shift, trial subtract, restore on borrow.
  always_comb begin
    r_sh  = {r, q[N-1]};
    diff  = r_sh - {1'b0, d};
    ge    = (r_sh >= {1'b0, d});
    q_ext = {q, ge};
    q_nx  = q_ext[N-1:0];
    r_nx  = N'(ge ? diff : r_sh);
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      out         <= '0;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
`ifdef U_SEQ_DIV_ZERO_FAST_EN
      zf          <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          q           <= a;
          d           <= b;
          r           <= '0;
          cnt         <= CW'(N - 1);
          div_by_zero <= (b == '0);
          busy        <= 1'b1;
          state       <= RUN;
`ifdef U_SEQ_DIV_ZERO_FAST_EN
          zf          <= (b == '0);
`endif
        end
      end else begin
`ifdef U_SEQ_DIV_ZERO_FAST_EN
        if (zf) begin
          // q still holds the dividend: result is {a, all ones}.
          out   <= {q, {N{1'b1}}};
          done  <= 1'b1;
          busy  <= 1'b0;
          zf    <= 1'b0;
          state <= IDLE;
        end else
`endif
        begin
          q   <= q_nx;
          r   <= r_nx;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            out   <= {r_nx, q_nx};
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_u_seq_div.sv
// tb_u_seq_div: directed self-checking bench for u_seq_div at N=4 and N=1.
module tb_u_seq_div;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic       dbz;
  logic [7:0] out;

  logic       start1;
  logic       a1;
  logic       b1;
  logic       busy1;
  logic       done1;
  logic       dbz1;
  logic [1:0] out1;

  int total;
  int bad;

`ifdef U_SEQ_DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 4;
`endif

  u_seq_div #(.N(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(dbz), .out(out)
  );

  u_seq_div #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .div_by_zero(dbz1), .out(out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until done is seen on the N=4 instance; 999 on timeout.
  task automatic wait_done(input int limit, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < limit) begin
      step();
      cyc++;
      seen = (done === 1'b1);
    end
    if (!seen) cyc = 999;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
    total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out: got %h expected 00", out); end
    total++; if (out1 !== 2'b00) begin bad++; $display("FAIL reset_out1: got %b expected 00", out1); end
  endtask

  task automatic test_basic();
    int c;
    a = 4'd13; b = 4'd3; start = 1'b1;
    step();
    start = 1'b0; a = 4'd0; b = 4'd0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_run: got %b expected 1", busy); end
    wait_done(20, c);
    total++; if (c !== 4) begin bad++; $display("FAIL basic_latency: got %0d expected 4", c); end
    total++; if (out !== 8'h14) begin bad++; $display("FAIL basic_out: got %h expected 14", out); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL basic_dbz: got %b expected 0", dbz); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b expected 0", done); end
  endtask

  // Start held high: the done cycle is idle, so the next accept lands on
  // the edge right after done and the next done follows N+1 edges later.
  task automatic test_back_to_back();
    int c;
    a = 4'd3; b = 4'd7; start = 1'b1;
    step();
    a = 4'd15; b = 4'd1;
    wait_done(20, c);
    total++; if (c !== 4) begin bad++; $display("FAIL b2b_latency1: got %0d expected 4", c); end
    total++; if (out !== 8'h30) begin bad++; $display("FAIL b2b_out1: got %h expected 30", out); end
    wait_done(20, c);
    start = 1'b0;
    total++; if (c !== 5) begin bad++; $display("FAIL b2b_spacing: got %0d expected 5", c); end
    total++; if (out !== 8'h0F) begin bad++; $display("FAIL b2b_out2: got %h expected 0f", out); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_third: got busy %b expected 0", busy); end
  endtask

  task automatic test_div_zero();
    int c;
    a = 4'd5; b = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dz_flag_accept: got %b expected 1", dbz); end
    wait_done(20, c);
    total++; if (c !== ZLAT) begin bad++; $display("FAIL dz_latency: got %0d expected %0d", c, ZLAT); end
    total++; if (out !== 8'h5F) begin bad++; $display("FAIL dz_out: got %h expected 5f", out); end
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b expected 1", dbz); end
    step();
    step();
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dz_flag_hold: got %b expected 1", dbz); end
  endtask

  task automatic test_ignore_busy();
    int c;
    int extra;
    a = 4'd9; b = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 4'd1; b = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(20, c);
    total++; if (c !== 1) begin bad++; $display("FAIL ign_latency: got %0d expected 1", c); end
    total++; if (out !== 8'h14) begin bad++; $display("FAIL ign_out: got %h expected 14", out); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ign_extra_done: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_abort();
    int c;
    int dn;
    a = 4'd14; b = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    total++; if (out !== 8'h00) begin bad++; $display("FAIL abort_out: got %h expected 00", out); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b expected 0", done); end
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1) dn++;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL abort_late_done: got %0d expected 0", dn); end
    a = 4'd14; b = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(20, c);
    total++; if (c !== 4) begin bad++; $display("FAIL abort_rerun_latency: got %0d expected 4", c); end
    total++; if (out !== 8'h24) begin bad++; $display("FAIL abort_rerun_out: got %h expected 24", out); end
  endtask

  task automatic test_exhaustive();
    int c;
    logic [7:0] exp;
    logic [3:0] qq;
    logic [3:0] rr;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (j == 0) begin
          qq = 4'hF;
          rr = 4'(i);
        end else begin
          qq = 4'(i / j);
          rr = 4'(i % j);
        end
        exp = {rr, qq};
        a = 4'(i); b = 4'(j); start = 1'b1;
        step();
        start = 1'b0;
        wait_done(20, c);
        total++;
        if (out !== exp || c !== ((j == 0) ? ZLAT : 4)) begin
          bad++;
          $display("FAIL exh_%0d_%0d: got out %h lat %0d expected out %h", i, j, out, c, exp);
        end
      end
    end
  endtask

  task automatic test_n1();
    logic [1:0] exp [4];
    logic       va  [4];
    logic       vb  [4];
    int         c;
    bit         seen;
    va[0] = 1'b1; vb[0] = 1'b1; exp[0] = 2'b01;
    va[1] = 1'b0; vb[1] = 1'b1; exp[1] = 2'b00;
    va[2] = 1'b1; vb[2] = 1'b0; exp[2] = 2'b11;
    va[3] = 1'b0; vb[3] = 1'b0; exp[3] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      a1 = va[k]; b1 = vb[k]; start1 = 1'b1;
      step();
      start1 = 1'b0;
      seen = 1'b0;
      c = 0;
      while (!seen && c < 10) begin
        step();
        c++;
        seen = (done1 === 1'b1);
      end
      total++;
      if (!seen || c !== 1 || out1 !== exp[k] || dbz1 !== (vb[k] == 1'b0)) begin
        bad++;
        $display("FAIL n1_%0d: got out %b lat %0d dbz %b expected out %b lat 1", k, out1, c, dbz1, exp[k]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0; a = 4'd0; b = 4'd0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_busy();
    test_reset_abort();
    test_exhaustive();
    test_n1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
